// File: rtl/apb_fifo_mc.sv
// apb_fifo_mc: APB3 slave fronting NCH independent synchronous FIFOs.
// Each channel is pushed through APB registers (CTRL/STATUS/WDATA/THRESH at
// channel*0x10) and drained through its own first-word-fall-through
// valid/ready stream port.
//
// Optional build macro: APB_FIFO_MC_SLVERR_EN
//   defined   -> PSLVERR flags pushes to full/disabled channels and any
//                access to a channel index >= NCH
//   undefined -> PSLVERR tied to 0
//
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE APB3 control
//   PADDR[7:0]          [7:4] channel, [3:2] register, [1:0] ignored
//   PWDATA/PRDATA       APB data (PRDATA combinational in access phase)
//   PREADY, PSLVERR     always-ready, optional error response
//   m_valid/m_ready     per-channel stream handshake
//   m_data              channel c at [c*DW +: DW]
//   irq                 OR of enabled OVF/AFULL conditions over channels
module apb_fifo_mc #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int NCH   = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NCH-1:0]    m_valid,
  input  logic [NCH-1:0]    m_ready,
  output logic [NCH*DW-1:0] m_data,
  output logic              irq
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_WDATA  = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  logic          access;
  logic [3:0]    ch;
  logic [1:0]    rsel;
  logic          ch_ok;

  logic [DW-1:0] mem [NCH][DEPTH];
  logic [PW-1:0] wptr [NCH];
  logic [PW-1:0] rptr [NCH];
  logic [LW-1:0] thresh [NCH];
  logic [NCH-1:0] en, ovf_ie, afull_ie, ovf;

  logic [LW-1:0] level [NCH];
  logic [NCH-1:0] empty, full, afull;
  logic [NCH-1:0] sel, push, rej, pop, flush, ovf_clr;

  logic unused;

  assign access = PSEL & PENABLE;
  assign ch     = PADDR[7:4];
  assign rsel   = PADDR[3:2];
  assign ch_ok  = ({1'b0, ch} < 5'(NCH));
  assign PREADY = 1'b1;
  assign unused = ^{PADDR[1:0], PWDATA};

  // Flags derived purely from registered pointers/threshold.
  always_comb begin
    empty = '0;
    full  = '0;
    afull = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      level[c] = LW'(wptr[c] - rptr[c]);
      empty[c] = (wptr[c] == rptr[c]);
      full[c]  = (wptr[c][AW-1:0] == rptr[c][AW-1:0]) && (wptr[c][AW] != rptr[c][AW]);
      afull[c] = (LW'(wptr[c] - rptr[c]) >= thresh[c]);
    end
  end

  // Per-channel transfer decode.
  always_comb begin
    sel     = '0;
    push    = '0;
    rej     = '0;
    pop     = '0;
    flush   = '0;
    ovf_clr = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      sel[c]     = access && ch_ok && (ch == 4'(c));
      flush[c]   = sel[c] && PWRITE && (rsel == REG_CTRL) && PWDATA[1];
      push[c]    = sel[c] && PWRITE && (rsel == REG_WDATA) && en[c] && !full[c];
      rej[c]     = sel[c] && PWRITE && (rsel == REG_WDATA) && en[c] && full[c];
      ovf_clr[c] = sel[c] && PWRITE && (rsel == REG_STATUS) && PWDATA[2];
      pop[c]     = !empty[c] && m_ready[c];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        wptr[c]   <= '0;
        rptr[c]   <= '0;
        thresh[c] <= LW'(DEPTH);
      end
      en       <= '0;
      ovf_ie   <= '0;
      afull_ie <= '0;
      ovf      <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        // Flush overrides a concurrent pop; a push cannot coincide with it.
        if (flush[c]) begin
          wptr[c] <= '0;
          rptr[c] <= '0;
        end else begin
          if (push[c]) wptr[c] <= wptr[c] + PW'(1);
          if (pop[c])  rptr[c] <= rptr[c] + PW'(1);
        end
        if (sel[c] && PWRITE) begin
          case (rsel)
            REG_CTRL: begin
              en[c]       <= PWDATA[0];
              ovf_ie[c]   <= PWDATA[2];
              afull_ie[c] <= PWDATA[3];
            end
            REG_THRESH: thresh[c] <= PWDATA[LW-1:0];
            default: ;
          endcase
        end
        // A rejected push outranks a same-edge W1C.
        if (rej[c])          ovf[c] <= 1'b1;
        else if (ovf_clr[c]) ovf[c] <= 1'b0;
      end
    end
  end

  // Storage needs no reset: contents are only visible while non-empty.
  always_ff @(posedge PCLK) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (push[c] && !PRESET) mem[c][wptr[c][AW-1:0]] <= PWDATA[DW-1:0];
    end
  end

  assign m_valid = ~empty;

  always_comb begin
    m_data = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!empty[c]) m_data[c*DW +: DW] = mem[c][rptr[c][AW-1:0]];
    end
  end

  assign irq = |((ovf & ovf_ie) | (afull & afull_ie));

  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE && ch_ok) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (ch == 4'(c)) begin
          case (rsel)
            REG_CTRL:   PRDATA[3:0] = {afull_ie[c], ovf_ie[c], 1'b0, en[c]};
            REG_STATUS: begin
              PRDATA[16 +: LW] = level[c];
              PRDATA[3:0]      = {afull[c], ovf[c], full[c], empty[c]};
            end
            REG_THRESH: PRDATA[LW-1:0] = thresh[c];
            default: ;
          endcase
        end
      end
    end
  end

`ifdef APB_FIFO_MC_SLVERR_EN
  always_comb begin
    PSLVERR = 1'b0;
    if (access) begin
      if (!ch_ok) begin
        PSLVERR = 1'b1;
      end else begin
        for (int unsigned c = 0; c < NCH; c++) begin
          if ((ch == 4'(c)) && PWRITE && (rsel == REG_WDATA) && (!en[c] || full[c]))
            PSLVERR = 1'b1;
        end
      end
    end
  end
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_fifo_mc.sv
// Self-checking bench for apb_fifo_mc (DW=8, DEPTH=8, NCH=4).
module tb_apb_fifo_mc;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int NCH = 4;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [7:0]        PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [NCH-1:0]    m_valid;
  logic [NCH-1:0]    m_ready = '0;
  logic [NCH*DW-1:0] m_data;
  logic              irq;

  apb_fifo_mc #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_pass = 0;
  int n_total = 0;

  // Scoreboard: words the model expects each channel to emit, in order.
  logic [DW-1:0]  q [NCH][$];
  logic [NCH-1:0] model_en = '0;

`ifdef APB_FIFO_MC_SLVERR_EN
  localparam logic SLVERR_EXP = 1'b1;
`else
  localparam logic SLVERR_EXP = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;     // write data, or expected read data
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One APB transfer (setup + access). pop_mask raises m_ready only for the
  // access-phase edge so a pop coincides exactly with the transfer.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [NCH-1:0] pop_mask,
                     output logic [31:0] rdata, output logic slverr);
    int ci;
    ci = int'(addr[7:4]);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    if (wr && ci < NCH) begin
      if (addr[3:2] == 2'd0) begin
        model_en[ci] = wdata[0];
        if (wdata[1]) q[ci].delete();
      end else if (addr[3:2] == 2'd2) begin
        if (model_en[ci] && q[ci].size() < DEPTH) q[ci].push_back(wdata[DW-1:0]);
      end
    end
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    m_ready = m_ready | pop_mask;
    #1;
    rdata  = PRDATA;
    slverr = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    m_ready = m_ready & ~pop_mask;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic se;
    apb(1'b1, addr, data, '0, rd, se);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic se;
    apb(1'b0, addr, 32'h0, '0, rd, se);
    check(name, rd, exp);
  endtask

  task automatic drain(input int c);
    @(posedge PCLK); #1;
    m_ready[c] = 1'b1;
    for (int k = 0; k < 40 && (q[c].size() != 0 || m_valid[c]); k++) begin
      @(posedge PCLK); #1;
    end
    m_ready[c] = 1'b0;
    check($sformatf("drain_ch%0d_left", c), q[c].size(), 0);
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1;
    PRESET = 1'b1; m_ready = '0; PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    for (int c = 0; c < NCH; c++) q[c].delete();
    model_en = '0;
  endtask

  // Pop monitor: a handshake seen before the edge must carry the model head.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      for (int c = 0; c < NCH; c++) begin
        if (m_valid[c] && m_ready[c]) begin
          if (q[c].size() == 0) begin
            n_total++;
            $display("FAIL pop_ch%0d: popped 0x%02h, expected no word", c, m_data[c*DW +: DW]);
          end else begin
            check($sformatf("pop_ch%0d", c), 32'(m_data[c*DW +: DW]), 32'(q[c].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic se;

    // wr, addr, data/expected, chk_irq, exp_irq
    vt.push_back('{1'b0, 8'h00, 32'h0000_0000, 1'b1, 1'b0});
    vt.push_back('{1'b0, 8'h04, 32'h0000_0001, 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h0C, 32'h0000_0008, 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h08, 32'h0000_0000, 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h34, 32'h0000_0001, 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h3C, 32'h0000_0008, 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h44, 32'h0000_0000, 1'b0, 1'b0});
    vt.push_back('{1'b1, 8'h4C, 32'h0000_0005, 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h4C, 32'h0000_0000, 1'b0, 1'b0});
    vt.push_back('{1'b1, 8'h20, 32'h0000_0005, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) vt.push_back('{1'b1, 8'h28, 32'hA0 + 32'(i), 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h24, 32'h0008_000A, 1'b1, 1'b0});
    vt.push_back('{1'b1, 8'h28, 32'h0000_00AA, 1'b1, 1'b1});
    vt.push_back('{1'b0, 8'h24, 32'h0008_000E, 1'b0, 1'b0});
    vt.push_back('{1'b1, 8'h24, 32'h0000_0004, 1'b1, 1'b0});
    vt.push_back('{1'b0, 8'h24, 32'h0008_000A, 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h20, 32'h0000_0005, 1'b0, 1'b0});

    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    #2;
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_data", 32'(m_data), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pready", 32'(PREADY), 32'h1);
    check("rst_prdata_idle", PRDATA, 32'h0);
    check("rst_pslverr_idle", 32'(PSLVERR), 32'h0);

    // Register table, including the ch2 overflow / W1C scenario.
    foreach (vt[i]) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wr ? vt[i].data : 32'h0, '0, rd, se);
      if (!vt[i].wr) check($sformatf("vec%0d_rd_%02h", i, vt[i].addr), rd, vt[i].data);
      if (vt[i].chk_irq) check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vt[i].exp_irq));
    end
    drain(2);
    rd_chk("ch2_status_drained", 8'h24, 32'h0000_0001);

    // ch0 in-order round trip.
    wr(8'h00, 32'h1);
    for (int i = 0; i < 8; i++) wr(8'h08, 32'h10 + 32'(i));
    rd_chk("ch0_status_full", 8'h04, 32'h0008_000A);
    drain(0);
    rd_chk("ch0_status_end", 8'h04, 32'h0000_0001);
    rd_chk("ch1_status_untouched", 8'h14, 32'h0000_0001);
    rd_chk("ch1_ctrl_untouched", 8'h10, 32'h0000_0000);

    // ch1 almost-full threshold and interrupt.
    wr(8'h1C, 32'h3);
    wr(8'h10, 32'h9);
    rd_chk("ch1_thresh", 8'h1C, 32'h3);
    wr(8'h18, 32'hB0);
    wr(8'h18, 32'hB1);
    check("ch1_irq_lvl2", 32'(irq), 32'h0);
    wr(8'h18, 32'hB2);
    check("ch1_irq_lvl3", 32'(irq), 32'h1);
    rd_chk("ch1_status_afull", 8'h14, 32'h0003_0008);
    @(posedge PCLK); #1 m_ready[1] = 1'b1;
    @(posedge PCLK); #1 m_ready[1] = 1'b0;
    check("ch1_irq_after_pop", 32'(irq), 32'h0);
    rd_chk("ch1_status_after_pop", 8'h14, 32'h0002_0000);
    drain(1);

    // ch3 push at FULL with a concurrent pop, then push+pop at level 4.
    wr(8'h30, 32'h1);
    for (int i = 0; i < 8; i++) wr(8'h38, 32'hC0 + 32'(i));
    rd_chk("ch3_status_full", 8'h34, 32'h0008_000A);
    apb(1'b1, 8'h38, 32'hCF, 4'b1000, rd, se);
    rd_chk("ch3_status_rej_pop", 8'h34, 32'h0007_0004);
    @(posedge PCLK); #1 m_ready[3] = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 m_ready[3] = 1'b0;
    rd_chk("ch3_status_lvl4", 8'h34, 32'h0004_0004);
    apb(1'b1, 8'h38, 32'hD0, 4'b1000, rd, se);
    rd_chk("ch3_status_pushpop", 8'h34, 32'h0004_0004);
    drain(3);

    // Flush, then wrap the pointers with streaming traffic.
    for (int i = 0; i < 5; i++) wr(8'h08, 32'h30 + 32'(i));
    rd_chk("ch0_status_5", 8'h04, 32'h0005_0000);
    wr(8'h00, 32'h3);
    check("flush_m_valid", 32'(m_valid[0]), 32'h0);
    rd_chk("flush_status", 8'h04, 32'h0000_0001);
    rd_chk("flush_ctrl", 8'h00, 32'h0000_0001);
    @(posedge PCLK); #1 m_ready[0] = 1'b1;
    for (int i = 0; i < 20; i++) wr(8'h08, 32'h40 + 32'(i));
    drain(0);
    rd_chk("wrap_status", 8'h04, 32'h0000_0001);

    // Error responses.
    wr(8'h00, 32'h0);
    apb(1'b1, 8'h08, 32'h55, '0, rd, se);
    check("slverr_push_dis", 32'(se), 32'(SLVERR_EXP));
    rd_chk("dis_push_status", 8'h04, 32'h0000_0001);
    apb(1'b0, 8'h48, 32'h0, '0, rd, se);
    check("slverr_bad_ch", 32'(se), 32'(SLVERR_EXP));
    check("bad_ch_rdata", rd, 32'h0);

    // Reset in the middle of activity.
    wr(8'h10, 32'h9);
    wr(8'h1C, 32'h1);
    wr(8'h18, 32'hE0);
    wr(8'h18, 32'hE1);
    check("pre_rst_irq", 32'(irq), 32'h1);
    do_reset();
    check("mid_rst_m_valid", 32'(m_valid), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    rd_chk("mid_rst_status", 8'h14, 32'h0000_0001);
    rd_chk("mid_rst_ctrl", 8'h10, 32'h0000_0000);
    rd_chk("mid_rst_thresh", 8'h1C, 32'h0000_0008);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
